// File: rtl/adder_tree_loader_if.sv
// rtl/adder_tree_loader_if.sv - stream, adder-tree and result signals of the adder tree loader
interface adder_tree_loader_if #(
    parameter int W          = 16,
    parameter int NUM_INPUTS = 8
);
    localparam int SUM_W = W + $clog2(NUM_INPUTS);
    localparam int CNT_W = $clog2(NUM_INPUTS + 1);

    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [W-1:0]     tree_inputs [NUM_INPUTS];
    logic [SUM_W-1:0] tree_sum;
    logic [SUM_W-1:0] sum_out;
    logic             sum_valid;
    logic             sum_ready;
    logic [CNT_W-1:0] count_out;

    modport master (
        input  in_data, in_valid, in_last, tree_sum, sum_ready,
        output in_ready, tree_inputs, sum_out, sum_valid, count_out
    );

    modport slave (
        output in_data, in_valid, in_last, tree_sum, sum_ready,
        input  in_ready, tree_inputs, sum_out, sum_valid, count_out
    );
endinterface

// File: rtl/adder_tree_loader.sv
// rtl/adder_tree_loader.sv - buffers a sample group into adder-tree slots and captures the tree sum
module adder_tree_loader #(
    parameter int W            = 16,
    parameter int NUM_INPUTS   = 8,
    parameter int TREE_LATENCY = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    adder_tree_loader_if.master   bus
);
    localparam int SUM_W = W + $clog2(NUM_INPUTS);
    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {LOAD, WAIT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     slots [NUM_INPUTS];
    logic [CNT_W-1:0] count;
    logic [3:0]       wait_cnt;
    logic [SUM_W-1:0] sum_reg;
    logic             ready;
    logic             valid;
    logic             accept;
    logic             capture;
    logic             release_grp;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        valid       = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        release_grp = 1'b0;
        case (state)
            LOAD: begin
                ready  = 1'b1;
                accept = bus.in_valid;
                // Filling the final slot closes the group even without in_last.
                if (accept && (bus.in_last || count == LAST_IDX)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (bus.sum_ready) begin
                    release_grp = 1'b1;
                    state_next  = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                slots[i] <= '0;
            end
            count    <= '0;
            wait_cnt <= '0;
            sum_reg  <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (count == CNT_W'(i)) begin
                        slots[i] <= bus.in_data;
                    end
                end
                count <= count + 1'b1;
            end
            // Preloaded while loading so WAIT spans exactly TREE_LATENCY+1 cycles.
            if (state == LOAD) begin
                wait_cnt <= 4'(TREE_LATENCY);
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (capture) begin
                sum_reg <= bus.tree_sum;
            end
            if (release_grp) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    slots[i] <= '0;
                end
                count <= '0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            bus.tree_inputs[i] = slots[i];
        end
    end

    assign bus.in_ready  = ready;
    assign bus.sum_valid = valid;
    assign bus.sum_out   = sum_reg;
    assign bus.count_out = count;
endmodule

// File: tb/tb_adder_tree_loader.sv
// tb/tb_adder_tree_loader.sv - directed self-checking bench for adder_tree_loader
module tb_adder_tree_loader;
    localparam int W     = 16;
    localparam int N     = 8;
    localparam int TL    = 3;
    localparam int SUM_W = W + $clog2(N);

    logic clock;
    logic reset;
    int   passed;
    int   total;
    logic to_err;

    adder_tree_loader_if #(.W(W), .NUM_INPUTS(N)) bus ();

    adder_tree_loader #(.W(W), .NUM_INPUTS(N), .TREE_LATENCY(TL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Adder tree stand-in: combinational sum followed by TL pipeline stages.
    logic [SUM_W-1:0] comb_sum;
    logic [SUM_W-1:0] pipe [TL];
    always_comb begin
        comb_sum = '0;
        for (int i = 0; i < N; i++) comb_sum = comb_sum + SUM_W'(bus.tree_inputs[i]);
    end
    always @(posedge clock) begin
        pipe[0] <= comb_sum;
        for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.tree_sum = pipe[TL-1];

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        bus.sum_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        int n;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) to_err = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        logic any_nz;
        do_reset();
        any_nz = 1'b0;
        for (int i = 0; i < N; i++) if (bus.tree_inputs[i] !== '0) any_nz = 1'b1;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else passed++;
        total++;
        if (bus.sum_valid !== 1'b0 || bus.sum_out !== '0 || bus.count_out !== '0 || any_nz !== 1'b0)
            $display("FAIL reset_state got sv=%0b so=%0d cnt=%0d nz=%0b want 0 0 0 0",
                     bus.sum_valid, bus.sum_out, bus.count_out, any_nz);
        else passed++;
    endtask

    task automatic test_full_group();
        int n;
        do_reset();
        for (int i = 1; i <= 8; i++) send(W'(i), i == 8);
        total++;
        if (bus.count_out !== 4'd8) $display("FAIL full_count got %0d want 8", bus.count_out); else passed++;
        n = 1;
        while (bus.sum_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n !== TL + 2) $display("FAIL full_latency got %0d want %0d", n, TL + 2); else passed++;
        total++;
        if (bus.sum_out !== 19'd36) $display("FAIL full_sum got %0d want 36", bus.sum_out); else passed++;
        @(negedge clock);
        total++;
        if (bus.sum_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL full_one_cycle got sv=%0b rdy=%0b want 0 1", bus.sum_valid, bus.in_ready);
        else passed++;
    endtask

    task automatic test_short_group();
        logic bad;
        int   n;
        do_reset();
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        send(16'd300, 1'b1);
        bad = 1'b0;
        for (int i = 3; i < N; i++) if (bus.tree_inputs[i] !== '0) bad = 1'b1;
        total++;
        if (bad !== 1'b0 || bus.tree_inputs[0] !== 16'd100 || bus.tree_inputs[2] !== 16'd300)
            $display("FAIL short_slots got s0=%0d s2=%0d tail_nz=%0b want 100 300 0",
                     bus.tree_inputs[0], bus.tree_inputs[2], bad);
        else passed++;
        n = 0;
        while (bus.sum_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (bus.sum_out !== 19'd600 || bus.count_out !== 4'd3)
            $display("FAIL short_sum got %0d cnt %0d want 600 3", bus.sum_out, bus.count_out);
        else passed++;
    endtask

    task automatic test_implied_last();
        int   n;
        logic bad;
        do_reset();
        for (int i = 0; i < 8; i++) send(16'hFFFF, 1'b0);
        total++;
        if (bus.in_ready !== 1'b0) $display("FAIL implied_ready got %0b want 0", bus.in_ready); else passed++;
        bus.in_data  = 16'd1234;
        bus.in_valid = 1'b1;
        n   = 0;
        bad = 1'b0;
        while (bus.sum_valid !== 1'b1 && n < 50) begin
            if (bus.count_out !== 4'd8) bad = 1'b1;
            @(negedge clock);
            n++;
        end
        total++;
        if (bus.sum_out !== 19'd524280 || bad !== 1'b0)
            $display("FAIL implied_sum got %0d held=%0b want 524280 0", bus.sum_out, bad);
        else passed++;
        @(negedge clock);
        total++;
        if (bus.count_out !== 4'd0 || bus.in_ready !== 1'b1)
            $display("FAIL implied_release got cnt=%0d rdy=%0b want 0 1", bus.count_out, bus.in_ready);
        else passed++;
        @(negedge clock);
        bus.in_valid = 1'b0;
        total++;
        if (bus.count_out !== 4'd1 || bus.tree_inputs[0] !== 16'd1234)
            $display("FAIL implied_ninth got cnt=%0d s0=%0d want 1 1234", bus.count_out, bus.tree_inputs[0]);
        else passed++;
    endtask

    task automatic test_backpressure();
        int   n;
        logic bad;
        do_reset();
        bus.sum_ready = 1'b0;
        send(16'd10, 1'b0);
        send(16'd20, 1'b1);
        n = 0;
        while (bus.sum_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        bus.in_data  = 16'd99;
        bus.in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.sum_valid !== 1'b1 || bus.sum_out !== 19'd30 || bus.in_ready !== 1'b0 || bus.count_out !== 4'd2)
                bad = 1'b1;
            @(negedge clock);
        end
        total++;
        if (bad !== 1'b0) $display("FAIL backpressure_hold got unstable=%0b want 0 (sum %0d)", bad, bus.sum_out);
        else passed++;
        bus.sum_ready = 1'b1;
        @(negedge clock);
        total++;
        if (bus.in_ready !== 1'b1 || bus.sum_valid !== 1'b0 || bus.count_out !== 4'd0)
            $display("FAIL backpressure_release got rdy=%0b sv=%0b cnt=%0d want 1 0 0",
                     bus.in_ready, bus.sum_valid, bus.count_out);
        else passed++;
        @(negedge clock);
        bus.in_valid = 1'b0;
        total++;
        if (bus.count_out !== 4'd1 || bus.tree_inputs[0] !== 16'd99)
            $display("FAIL backpressure_next got cnt=%0d s0=%0d want 1 99", bus.count_out, bus.tree_inputs[0]);
        else passed++;
    endtask

    task automatic test_reset_wait();
        logic pulse;
        logic any_nz;
        int   n;
        do_reset();
        send(16'd7, 1'b0);
        send(16'd9, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        any_nz = 1'b0;
        for (int i = 0; i < N; i++) if (bus.tree_inputs[i] !== '0) any_nz = 1'b1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.sum_out !== '0 || bus.count_out !== '0 || any_nz !== 1'b0)
            $display("FAIL reset_wait_clear got rdy=%0b so=%0d cnt=%0d nz=%0b want 1 0 0 0",
                     bus.in_ready, bus.sum_out, bus.count_out, any_nz);
        else passed++;
        pulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.sum_valid !== 1'b0) pulse = 1'b1;
            @(negedge clock);
        end
        total++;
        if (pulse !== 1'b0) $display("FAIL reset_wait_pulse got %0b want 0", pulse); else passed++;
        send(16'd5, 1'b0);
        send(16'd5, 1'b1);
        n = 0;
        while (bus.sum_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (bus.sum_out !== 19'd10) $display("FAIL reset_wait_next got %0d want 10", bus.sum_out); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [SUM_W-1:0] got [$];
        do_reset();
        fork
            begin
                send(16'd1, 1'b0);
                send(16'd2, 1'b0);
                send(16'd3, 1'b1);
                send(16'd4, 1'b0);
                send(16'd5, 1'b1);
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(negedge clock);
                    if (bus.sum_valid === 1'b1 && bus.sum_ready === 1'b1) got.push_back(bus.sum_out);
                end
            end
        join
        total++;
        if (got.size() !== 2) $display("FAIL b2b_count got %0d want 2", got.size());
        else passed++;
        total++;
        if (got.size() < 2 || got[0] !== 19'd6 || got[1] !== 19'd9)
            $display("FAIL b2b_values got %0d sums (first %0d) want 6 then 9", got.size(),
                     got.size() > 0 ? got[0] : '0);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        to_err = 1'b0;
        test_reset();
        test_full_group();
        test_short_group();
        test_implied_last();
        test_backpressure();
        test_reset_wait();
        test_back_to_back();
        total++;
        if (to_err !== 1'b0) $display("FAIL send_timeout got %0b want 0", to_err); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adder_tree_loader.md
ADDER_TREE_LOADER -- requirements
Module: adder_tree_loader

Interface
Parameters
REQ-001 SHALL have parameter W, default 16: width of each input sample.
REQ-002 SHALL have parameter NUM_INPUTS, default 8, legal range 2..256: adder-tree fan-in (number of buffer slots).
REQ-003 SHALL have parameter TREE_LATENCY, default 3, legal range 0..15: cycles from a stable tree_inputs to a valid tree_sum.
REQ-004 SHALL have derived parameter SUM_W = W + $clog2(NUM_INPUTS): width of tree_sum and sum_out.

Ports
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_data, input, W: stream sample.
REQ-008 SHALL have port in_valid, input, 1: in_data is valid.
REQ-009 SHALL have port in_last, input, 1: the current sample is the final sample of the group.
REQ-010 SHALL have port in_ready, output, 1: loader accepts a sample this cycle.
REQ-011 SHALL have port tree_inputs, output, NUM_INPUTS x W (unpacked array): parallel operands for the adder tree.
REQ-012 SHALL have port tree_sum, input, SUM_W: result returned by the adder tree.
REQ-013 SHALL have port sum_out, output, SUM_W: captured group sum.
REQ-014 SHALL have port sum_valid, output, 1: sum_out holds a valid result.
REQ-015 SHALL have port sum_ready, input, 1: downstream accepts sum_out.
REQ-016 SHALL have port count_out, output, $clog2(NUM_INPUTS+1): number of samples in the current or last group.

Function
REQ-017 SHALL implement a three-state FSM with states LOAD, WAIT and DONE.
REQ-018 A sample SHALL be accepted in a cycle when in_valid && in_ready is true.
REQ-019 SHALL assert in_ready only in the LOAD state.
REQ-020 In LOAD, an accepted sample SHALL be written into slot idx, after which idx and count_out increment by 1.
REQ-021 The FSM SHALL go LOAD->WAIT on an accepted sample that has in_last=1 or is written into slot NUM_INPUTS-1; in_last is then implied, and idx does not wrap into slot 0.
REQ-022 On entering WAIT, slots idx..NUM_INPUTS-1 that were not written in this group SHALL read as 0 on tree_inputs.
REQ-023 tree_inputs SHALL stay stable from entry to WAIT until the group is consumed in DONE.
REQ-024 WAIT SHALL last exactly TREE_LATENCY+1 cycles, counted by an internal down-counter, and then go to DONE.
REQ-025 On the last WAIT cycle, sum_out SHALL capture tree_sum, and sum_valid SHALL rise on the entry to DONE.
REQ-026 In DONE, sum_valid SHALL stay high and sum_out SHALL stay stable until sum_valid && sum_ready.
REQ-027 On handshake in DONE, the loader SHALL clear all slots to 0, reset idx and count_out to 0, deassert sum_valid and go to LOAD the next cycle; the handshake cycle is not also a load cycle.
REQ-028 in_valid presented while in WAIT or DONE SHALL be ignored, and in_data SHALL NOT be consumed.
REQ-029 A LOAD cycle with in_valid=0 SHALL leave all state unchanged; in_last without in_valid SHALL be ignored.
REQ-030 Total latency from the accepted last sample to sum_valid=1 SHALL be TREE_LATENCY+2 cycles.
REQ-031 Sum arithmetic SHALL be unsigned, with no overflow possible at width SUM_W.

Reset
REQ-032 When reset=1 at a clock edge, the FSM SHALL go to LOAD, idx=0, count_out=0, every slot of tree_inputs=0, sum_out=0 and sum_valid=0.
REQ-033 After reset, in_ready SHALL read 1 on the first cycle.
REQ-034 Reset SHALL take priority over any simultaneous handshake.
REQ-035 Reset asserted mid-LOAD, mid-WAIT or in DONE SHALL discard the partial group and any pending sum, with no sum_valid pulse afterwards.

Verification
REQ-036 Full group, paired with an adder_tree instance, NUM_INPUTS=8: stream 1..8 with in_last on 8, sum_ready=1 -> sum_out=36, count_out=8, sum_valid high for one cycle, TREE_LATENCY+2 cycles after the last accept.
REQ-037 Short group: stream 100, 200, 300 with in_last on 300 -> slots 3..7 equal 0, sum_out=600, count_out=3.
REQ-038 Implied last: 8 samples of 16'hFFFF with in_last=0 -> in_ready drops after the 8th accept; sum_out=8*65535=524280, which fits SUM_W=19; a 9th sample is not accepted until the handshake.
REQ-039 Backpressure: sum_ready=0 for 10 cycles in DONE -> sum_out and sum_valid held stable, in_ready=0 throughout, in_valid ignored; next group starts in the cycle after sum_ready=1.
REQ-040 Reset mid-WAIT: reset pulse 1 cycle after the last accept -> no sum_valid pulse, all outputs equal 0, in_ready=1; the next group of 5, 5 sums to 10.
REQ-041 Back-to-back: two groups sent with in_valid held high -> exactly two sums, matching gold values, with no sample lost or duplicated.
